// File: rtl/drive_sequencer.sv
// Drive-code to dual H-bridge sequencer: duty ramping, reversal dead-time, PWM, e-stop.
// Optional command watchdog enabled by defining DRV_TIMEOUT_EN.
module drive_sequencer #(
  parameter int RAMP_DIV    = 50000,
  parameter int RAMP_STEP   = 8,
  parameter int DEADTIME    = 25000,
  parameter int DUTY_SLOW   = 96,
  parameter int DUTY_MED    = 160,
  parameter int DUTY_FAST   = 240,
  parameter int DUTY_TURN   = 128,
  parameter int TIMEOUT_CYC = 5000000
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic [3:0] drive_state,
  input  logic       estop,
  input  logic       cmd_alive,
  output logic [7:0] left_duty,
  output logic [7:0] right_duty,
  output logic       left_dir,
  output logic       right_dir,
  output logic       pwm_left,
  output logic       pwm_right,
  output logic [1:0] seq_state,
  output logic       busy,
  output logic       timeout_flag
);

  typedef enum logic [3:0] {
    DS_STOP     = 4'd0,
    DS_LEFT     = 4'd1,
    DS_RIGHT    = 4'd2,
    DS_SLOW     = 4'd3,
    DS_MEDIUM   = 4'd4,
    DS_FAST     = 4'd5,
    DS_REVERSE  = 4'd6,
    DS_LREVERSE = 4'd7,
    DS_RREVERSE = 4'd8
  } drive_code_t;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    RAMP  = 2'd1,
    DECEL = 2'd2,
    DEAD  = 2'd3
  } seq_t;

  localparam int DIV_W  = $clog2(RAMP_DIV + 1);
  localparam int DEAD_W = $clog2(DEADTIME + 1);

  localparam logic [7:0] STEP8   = 8'(RAMP_STEP);
  localparam logic [7:0] D_SLOW  = 8'(DUTY_SLOW);
  localparam logic [7:0] D_HALF  = 8'(DUTY_SLOW >> 1);
  localparam logic [7:0] D_MED   = 8'(DUTY_MED);
  localparam logic [7:0] D_FAST  = 8'(DUTY_FAST);
  localparam logic [7:0] D_TURN  = 8'(DUTY_TURN);

  logic [3:0] cmd_code;

`ifdef DRV_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_cnt;

  always_ff @(posedge clk_50) begin
    if (reset) begin
      wd_cnt       <= '0;
      timeout_flag <= 1'b0;
    end else if (cmd_alive) begin
      wd_cnt       <= '0;
      timeout_flag <= 1'b0;
    end else if (wd_cnt == WD_W'(TIMEOUT_CYC - 1)) begin
      timeout_flag <= 1'b1;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign cmd_code = timeout_flag ? DS_STOP : drive_state;
`else
  logic unused_cmd_alive;
  assign unused_cmd_alive = cmd_alive;
  assign timeout_flag     = 1'b0;
  assign cmd_code         = drive_state;
`endif

  // Target mapping; STOP keeps the current dirs so it never triggers a reversal.
  logic [7:0] map_l_duty, map_r_duty;
  logic       map_l_dir,  map_r_dir;

  always_comb begin
    map_l_duty = '0;
    map_r_duty = '0;
    map_l_dir  = left_dir;
    map_r_dir  = right_dir;
    case (cmd_code)
      DS_LEFT: begin
        map_l_duty = D_TURN; map_l_dir = 1'b0;
        map_r_duty = D_TURN; map_r_dir = 1'b1;
      end
      DS_RIGHT: begin
        map_l_duty = D_TURN; map_l_dir = 1'b1;
        map_r_duty = D_TURN; map_r_dir = 1'b0;
      end
      DS_SLOW: begin
        map_l_duty = D_SLOW; map_l_dir = 1'b1;
        map_r_duty = D_SLOW; map_r_dir = 1'b1;
      end
      DS_MEDIUM: begin
        map_l_duty = D_MED; map_l_dir = 1'b1;
        map_r_duty = D_MED; map_r_dir = 1'b1;
      end
      DS_FAST: begin
        map_l_duty = D_FAST; map_l_dir = 1'b1;
        map_r_duty = D_FAST; map_r_dir = 1'b1;
      end
      DS_REVERSE: begin
        map_l_duty = D_SLOW; map_l_dir = 1'b0;
        map_r_duty = D_SLOW; map_r_dir = 1'b0;
      end
      DS_LREVERSE: begin
        map_l_duty = D_HALF; map_l_dir = 1'b0;
        map_r_duty = D_SLOW; map_r_dir = 1'b0;
      end
      DS_RREVERSE: begin
        map_l_duty = D_SLOW; map_l_dir = 1'b0;
        map_r_duty = D_HALF; map_r_dir = 1'b0;
      end
      default: ;
    endcase
  end

  logic [7:0] tgt_l_duty, tgt_r_duty;
  logic       tgt_l_dir,  tgt_r_dir;

  always_ff @(posedge clk_50) begin
    if (reset) begin
      tgt_l_duty <= '0;
      tgt_r_duty <= '0;
      tgt_l_dir  <= 1'b1;
      tgt_r_dir  <= 1'b1;
    end else begin
      tgt_l_duty <= map_l_duty;
      tgt_r_duty <= map_r_duty;
      tgt_l_dir  <= map_l_dir;
      tgt_r_dir  <= map_r_dir;
    end
  end

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  assign tick = (div_cnt == DIV_W'(RAMP_DIV - 1));

  function automatic logic [7:0] ramp_to(input logic [7:0] cur, input logic [7:0] tgt);
    if (tgt > cur)
      return ((tgt - cur) <= STEP8) ? tgt : cur + STEP8;
    else if (cur > tgt)
      return ((cur - tgt) <= STEP8) ? tgt : cur - STEP8;
    else
      return cur;
  endfunction

  seq_t              state_q, state_d;
  logic [DEAD_W-1:0] dead_cnt, dead_d;
  logic [7:0]        l_duty_d, r_duty_d;
  logic              l_dir_d,  r_dir_d;
  logic              flip_l, flip_r;
  logic [7:0]        eff_l, eff_r;

  // A flipping wheel always aims at 0 so a ramp tick can never push it the wrong way.
  assign flip_l = (tgt_l_dir != left_dir);
  assign flip_r = (tgt_r_dir != right_dir);
  assign eff_l  = flip_l ? 8'd0 : tgt_l_duty;
  assign eff_r  = flip_r ? 8'd0 : tgt_r_duty;

  always_comb begin
    state_d  = state_q;
    dead_d   = '0;
    l_duty_d = left_duty;
    r_duty_d = right_duty;
    l_dir_d  = left_dir;
    r_dir_d  = right_dir;
    if (estop) begin
      state_d  = DEAD;
      l_duty_d = '0;
      r_duty_d = '0;
    end else begin
      case (state_q)
        HOLD: begin
          if (flip_l || flip_r)
            state_d = DECEL;
          else if (left_duty != tgt_l_duty || right_duty != tgt_r_duty)
            state_d = RAMP;
        end
        RAMP: begin
          if (tick) begin
            l_duty_d = ramp_to(left_duty, eff_l);
            r_duty_d = ramp_to(right_duty, eff_r);
          end
          if (flip_l || flip_r)
            state_d = DECEL;
          else if (left_duty == tgt_l_duty && right_duty == tgt_r_duty)
            state_d = HOLD;
        end
        DECEL: begin
          if (tick) begin
            l_duty_d = ramp_to(left_duty, eff_l);
            r_duty_d = ramp_to(right_duty, eff_r);
          end
          if (!flip_l && !flip_r)
            state_d = RAMP;
          else if ((!flip_l || left_duty == 8'd0) && (!flip_r || right_duty == 8'd0))
            state_d = DEAD;
        end
        DEAD: begin
          if (dead_cnt == DEAD_W'(DEADTIME - 1)) begin
            l_dir_d = tgt_l_dir;
            r_dir_d = tgt_r_dir;
            state_d = RAMP;
          end else begin
            dead_d = dead_cnt + 1'b1;
          end
        end
        default: state_d = HOLD;
      endcase
    end
  end

  logic [7:0] pwm_cnt;

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_q    <= HOLD;
      dead_cnt   <= '0;
      div_cnt    <= '0;
      pwm_cnt    <= '0;
      left_duty  <= '0;
      right_duty <= '0;
      left_dir   <= 1'b1;
      right_dir  <= 1'b1;
      pwm_left   <= 1'b0;
      pwm_right  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dead_cnt   <= dead_d;
      div_cnt    <= tick ? '0 : div_cnt + 1'b1;
      pwm_cnt    <= pwm_cnt + 8'd1;
      left_duty  <= l_duty_d;
      right_duty <= r_duty_d;
      left_dir   <= l_dir_d;
      right_dir  <= r_dir_d;
      pwm_left   <= (pwm_cnt < left_duty);
      pwm_right  <= (pwm_cnt < right_duty);
    end
  end

  assign seq_state = state_q;
  assign busy      = (state_q != HOLD);

endmodule

// File: tb/tb_drive_sequencer.sv
// Directed bench for drive_sequencer with shortened ramp/dead-time parameters.
// The watchdog scenario runs only when DRV_TIMEOUT_EN is defined.
module tb_drive_sequencer;

  localparam logic [1:0] S_HOLD  = 2'd0;
  localparam logic [1:0] S_RAMP  = 2'd1;
  localparam logic [1:0] S_DECEL = 2'd2;
  localparam logic [1:0] S_DEAD  = 2'd3;

  logic       clk_50 = 1'b0;
  logic       reset;
  logic [3:0] drive_state;
  logic       estop;
  logic       cmd_alive;
  logic [7:0] left_duty, right_duty;
  logic       left_dir, right_dir, pwm_left, pwm_right;
  logic [1:0] seq_state;
  logic       busy, timeout_flag;

  int vectors = 0;
  int miscompares = 0;

  drive_sequencer #(
    .RAMP_DIV   (4),
    .RAMP_STEP  (16),
    .DEADTIME   (10),
    .DUTY_FAST  (192),
    .TIMEOUT_CYC(100)
  ) dut (
    .clk_50      (clk_50),
    .reset       (reset),
    .drive_state (drive_state),
    .estop       (estop),
    .cmd_alive   (cmd_alive),
    .left_duty   (left_duty),
    .right_duty  (right_duty),
    .left_dir    (left_dir),
    .right_dir   (right_dir),
    .pwm_left    (pwm_left),
    .pwm_right   (pwm_right),
    .seq_state   (seq_state),
    .busy        (busy),
    .timeout_flag(timeout_flag)
  );

  always #10 clk_50 = ~clk_50;

  task automatic cyc();
    @(posedge clk_50);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; drive_state = 4'd0; estop = 1'b0; cmd_alive = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
  endtask

  // Returns cycles waited, or -1 if the state never appeared within the limit.
  task automatic wait_state(input logic [1:0] s, input int limit, output int n);
    n = 0;
    while (seq_state !== s && n < limit) begin cyc(); n++; end
    if (seq_state !== s) n = -1;
  endtask

  // Follows left_duty until it equals target; records step sizes, spacing and states seen.
  task automatic track_ramp(input int target, input int step, input int limit,
                            output int changes, output int bad_step, output int bad_gap,
                            output logic [3:0] seen);
    int prev, last, n;
    prev = int'(left_duty); last = -1; n = 0;
    changes = 0; bad_step = 0; bad_gap = 0; seen = 4'b0;
    while (int'(left_duty) != target && n < limit) begin
      cyc(); n++;
      seen[seq_state] = 1'b1;
      if (int'(left_duty) != prev) begin
        if (int'(left_duty) != prev + step || right_duty !== left_duty) bad_step++;
        if (last >= 0 && n - last != 4) bad_gap++;
        last = n; changes++; prev = int'(left_duty);
      end
    end
  endtask

  task automatic test_reset();
    int highs;
    do_reset();
    vectors++;
    if ({left_duty, right_duty, left_dir, right_dir, pwm_left, pwm_right, seq_state, busy, timeout_flag}
        !== {8'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_values: got duty %0d/%0d dir %b%b pwm %b%b st %0d busy %b to %b, want 0/0 11 00 0 0 0",
               left_duty, right_duty, left_dir, right_dir, pwm_left, pwm_right, seq_state, busy, timeout_flag);
    end
    highs = 0;
    for (int i = 0; i < 256; i++) begin cyc(); if (pwm_left || pwm_right) highs++; end
    vectors++;
    if (highs !== 0) begin
      miscompares++; $display("FAIL pwm_zero_duty: got %0d high cycles, want 0", highs);
    end
  endtask

  task automatic test_fast_ramp();
    int ch, bs, bg, n;
    logic [3:0] seen;
    drive_state = 4'd5;
    track_ramp(192, 16, 300, ch, bs, bg, seen);
    vectors++;
    if (ch !== 12 || left_duty !== 8'd192) begin
      miscompares++; $display("FAIL fast_ramp_ticks: got %0d steps to duty %0d, want 12 steps to 192", ch, left_duty);
    end
    vectors++;
    if (bs !== 0 || bg !== 0 || seen[S_DECEL] || seen[S_DEAD]) begin
      miscompares++; $display("FAIL fast_ramp_shape: got bad_step %0d bad_gap %0d seen %b, want 0 0 no decel/dead", bs, bg, seen);
    end
    wait_state(S_HOLD, 10, n);
    vectors++;
    if (n < 0 || busy !== 1'b0 || left_dir !== 1'b1 || right_dir !== 1'b1 || right_duty !== 8'd192) begin
      miscompares++; $display("FAIL fast_hold: got wait %0d busy %b dirs %b%b rduty %0d, want hold busy 0 dirs 11 192",
                              n, busy, left_dir, right_dir, right_duty);
    end
  endtask

  task automatic test_reverse();
    int ch, bs, bg, n;
    logic [3:0] seen;
    drive_state = 4'd6;
    track_ramp(0, -16, 300, ch, bs, bg, seen);
    vectors++;
    if (ch !== 12 || bs !== 0 || !seen[S_DECEL] || left_dir !== 1'b1) begin
      miscompares++; $display("FAIL reverse_decel: got steps %0d bad %0d seen %b ldir %b, want 12 0 decel 1", ch, bs, seen, left_dir);
    end
    wait_state(S_DEAD, 10, n);
    vectors++;
    if (n < 0 || left_dir !== 1'b1 || right_dir !== 1'b1) begin
      miscompares++; $display("FAIL reverse_dead_entry: got wait %0d dirs %b%b, want dead with dirs 11", n, left_dir, right_dir);
    end
    n = 0;
    while (seq_state === S_DEAD && n < 50) begin n++; cyc(); end
    vectors++;
    if (n !== 10 || seq_state !== S_RAMP || left_dir !== 1'b0 || right_dir !== 1'b0) begin
      miscompares++; $display("FAIL reverse_deadtime: got %0d dead cycles then st %0d dirs %b%b, want 10 then ramp dirs 00",
                              n, seq_state, left_dir, right_dir);
    end
    track_ramp(96, 16, 300, ch, bs, bg, seen);
    wait_state(S_HOLD, 10, n);
    vectors++;
    if (ch !== 6 || bs !== 0 || n < 0 || right_duty !== 8'd96) begin
      miscompares++; $display("FAIL reverse_rampup: got steps %0d bad %0d wait %0d rduty %0d, want 6 0 hold 96", ch, bs, n, right_duty);
    end
  endtask

  task automatic test_left_pwm();
    int n, n2, hl, hr;
    do_reset();
    drive_state = 4'd1;
    wait_state(S_DECEL, 5, n);
    wait_state(S_DEAD, 5, n2);
    vectors++;
    if (n < 0 || n2 < 0) begin
      miscompares++; $display("FAIL left_decel_dead: got waits %0d %0d, want decel then dead", n, n2);
    end
    wait_state(S_RAMP, 20, n);
    vectors++;
    if (n < 0 || left_dir !== 1'b0 || right_dir !== 1'b1) begin
      miscompares++; $display("FAIL left_dirs: got wait %0d dirs %b%b, want ramp with dirs 01", n, left_dir, right_dir);
    end
    wait_state(S_HOLD, 200, n);
    vectors++;
    if (n < 0 || left_duty !== 8'd128 || right_duty !== 8'd128) begin
      miscompares++; $display("FAIL left_duties: got wait %0d duty %0d/%0d, want 128/128", n, left_duty, right_duty);
    end
    hl = 0; hr = 0;
    for (int i = 0; i < 256; i++) begin cyc(); if (pwm_left) hl++; if (pwm_right) hr++; end
    vectors++;
    if (hl !== 128 || hr !== 128) begin
      miscompares++; $display("FAIL pwm_128: got %0d/%0d high of 256, want 128/128", hl, hr);
    end
  endtask

  task automatic test_estop();
    int n, bad;
    do_reset();
    drive_state = 4'd5;
    n = 0;
    while (left_duty !== 8'd80 && n < 100) begin cyc(); n++; end
    vectors++;
    if (left_duty !== 8'd80 || seq_state !== S_RAMP) begin
      miscompares++; $display("FAIL estop_setup: got duty %0d st %0d, want 80 in ramp", left_duty, seq_state);
    end
    estop = 1'b1;
    cyc();
    vectors++;
    if (left_duty !== 8'd0 || right_duty !== 8'd0 || seq_state !== S_DEAD || left_dir !== 1'b1) begin
      miscompares++; $display("FAIL estop_hit: got duty %0d/%0d st %0d ldir %b, want 0/0 dead 1",
                              left_duty, right_duty, seq_state, left_dir);
    end
    bad = 0;
    cyc(); if (seq_state !== S_DEAD) bad++;
    cyc(); if (seq_state !== S_DEAD) bad++;
    estop = 1'b0;
    n = 0;
    while (seq_state === S_DEAD && n < 50) begin cyc(); n++; end
    vectors++;
    if (bad !== 0 || n !== 10 || seq_state !== S_RAMP) begin
      miscompares++; $display("FAIL estop_release: got held-bad %0d dead %0d then st %0d, want 0 10 ramp", bad, n, seq_state);
    end
    n = 0;
    while (left_duty === 8'd0 && n < 20) begin cyc(); n++; end
    vectors++;
    if (left_duty !== 8'd16) begin
      miscompares++; $display("FAIL estop_reclimb: got first duty %0d, want 16", left_duty);
    end
  endtask

  task automatic test_invalid_code();
    int ch, bs, bg, n;
    logic [3:0] seen;
    do_reset();
    drive_state = 4'd5;
    track_ramp(192, 16, 300, ch, bs, bg, seen);
    wait_state(S_HOLD, 10, n);
    drive_state = 4'd13;
    track_ramp(0, -16, 300, ch, bs, bg, seen);
    wait_state(S_HOLD, 10, n);
    vectors++;
    if (ch !== 12 || bs !== 0 || seen[S_DECEL] || seen[S_DEAD] || n < 0 ||
        left_dir !== 1'b1 || right_dir !== 1'b1 || right_duty !== 8'd0) begin
      miscompares++; $display("FAIL code13_stop: got steps %0d bad %0d seen %b wait %0d dirs %b%b rduty %0d, want 12 0 no decel hold 11 0",
                              ch, bs, seen, n, left_dir, right_dir, right_duty);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    drive_state = 4'd6;
    wait_state(S_DEAD, 20, n);
    reset = 1'b1; cyc(); reset = 1'b0;
    vectors++;
    if (n < 0 || seq_state !== S_HOLD || busy !== 1'b0 || left_dir !== 1'b1 || right_dir !== 1'b1 || left_duty !== 8'd0) begin
      miscompares++; $display("FAIL reset_mid_dead: got wait %0d st %0d busy %b dirs %b%b duty %0d, want hold 0 11 0",
                              n, seq_state, busy, left_dir, right_dir, left_duty);
    end
    drive_state = 4'd4;
    n = 0;
    while (left_duty !== 8'd48 && n < 100) begin cyc(); n++; end
    reset = 1'b1; cyc(); reset = 1'b0;
    vectors++;
    if (n >= 100 || left_duty !== 8'd0 || right_duty !== 8'd0 || seq_state !== S_HOLD || pwm_left !== 1'b0) begin
      miscompares++; $display("FAIL reset_mid_ramp: got n %0d duty %0d/%0d st %0d pwm %b, want 0/0 hold 0",
                              n, left_duty, right_duty, seq_state, pwm_left);
    end
  endtask

  task automatic test_timeout();
    int ch, bs, bg, n;
    logic [3:0] seen;
    logic f99;
    do_reset();
    drive_state = 4'd5;
`ifdef DRV_TIMEOUT_EN
    for (int i = 0; i < 99; i++) cyc();
    f99 = timeout_flag;
    cyc();
    vectors++;
    if (f99 !== 1'b0 || timeout_flag !== 1'b1) begin
      miscompares++; $display("FAIL timeout_edge: got flag %b at 99, %b at 100, want 0 then 1", f99, timeout_flag);
    end
    track_ramp(0, -16, 300, ch, bs, bg, seen);
    vectors++;
    if (left_duty !== 8'd0 || bs !== 0 || seen[S_DECEL] || left_dir !== 1'b1 || right_dir !== 1'b1) begin
      miscompares++; $display("FAIL timeout_stop: got duty %0d bad %0d seen %b dirs %b%b, want 0 0 no decel 11",
                              left_duty, bs, seen, left_dir, right_dir);
    end
    cmd_alive = 1'b1; cyc(); cmd_alive = 1'b0;
    vectors++;
    if (timeout_flag !== 1'b0) begin
      miscompares++; $display("FAIL timeout_clear: got flag %b, want 0", timeout_flag);
    end
    track_ramp(192, 16, 90, ch, bs, bg, seen);
    vectors++;
    if (left_duty !== 8'd192 || ch !== 12) begin
      miscompares++; $display("FAIL timeout_resume: got duty %0d steps %0d, want 192 12", left_duty, ch);
    end
`else
    for (int i = 0; i < 150; i++) cyc();
    f99 = timeout_flag;
    cmd_alive = 1'b1; cyc(); cmd_alive = 1'b0;
    track_ramp(192, 16, 10, ch, bs, bg, seen);
    vectors++;
    if (f99 !== 1'b0 || timeout_flag !== 1'b0 || left_duty !== 8'd192) begin
      miscompares++; $display("FAIL no_watchdog: got flag %b/%b duty %0d, want 0/0 192", f99, timeout_flag, left_duty);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_fast_ramp();
    test_reverse();
    test_left_pwm();
    test_estop();
    test_invalid_code();
    test_reset_mid();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
